// File: rtl/intr_pkg.sv
// Shared types and limits for the interrupt controller.
package intr_pkg;

  typedef enum logic {IDLE, REQ} intr_state_e;

  // Upper bound on the number of sources the controller supports.
  localparam int MAX_SRC = 32;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: reports the highest set index of the input vector.
module intr_prio_enc #(
  parameter int N_SRC = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] vec_i,
  output logic             any_o,
  output logic [ID_W-1:0]  idx_o
);

  assign any_o = |vec_i;

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (vec_i[i]) idx_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// N-source interrupt controller: per-source edge/level trigger, pending
// latches, mask, fixed highest-index priority and a req/ack handshake that
// holds the granted ID stable until the consumer acknowledges it.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SRC-1:0] src_i,
  input  logic [N_SRC-1:0] edge_mode_i,
  input  logic [N_SRC-1:0] mask_i,
  output logic             intr_o,
  output logic [ID_W-1:0]  id_o,
  input  logic             ack_i,
  output logic [N_SRC-1:0] pend_o
);

  if (N_SRC < 2 || N_SRC > MAX_SRC) begin : g_bad_n_src
    $error("intr_ctrl: N_SRC out of range 2..MAX_SRC");
  end

  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] rise, clr, elig;
  intr_state_e      state_q;
  logic             intr_q;
  logic [ID_W-1:0]  id_q;
  logic             any;
  logic [ID_W-1:0]  win_idx;
  logic             ack_acc;

  assign rise    = src_i & ~src_q;
  assign elig    = pend_q & mask_i;
  assign ack_acc = (state_q == REQ) && ack_i;

  // Per-source pending next state. For edge sources a new rise overrides the
  // acknowledge clear so an event landing on the ack cycle is not lost; level
  // sources simply track the line and ignore the clear.
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign clr[i]    = ack_acc && (id_q == ID_W'(i));
    assign pend_d[i] = edge_mode_i[i] ? ((pend_q[i] & ~clr[i]) | rise[i])
                                      : src_i[i];
  end

  intr_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio (
    .vec_i (elig),
    .any_o (any),
    .idx_o (win_idx)
  );

  // Edge-detect history and pending latches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q  <= '0;
      pend_q <= '0;
    end else begin
      src_q  <= src_i;
      pend_q <= pend_d;
    end
  end

  // Handshake FSM with registered request and ID; a request is never
  // withdrawn, and a newer higher-priority source waits for the next IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      intr_q  <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any) begin
            state_q <= REQ;
            intr_q  <= 1'b1;
            id_q    <= win_idx;
          end
        end
        REQ: begin
          if (ack_i) begin
            state_q <= IDLE;
            intr_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          intr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign intr_o = intr_q;
  assign id_o   = id_q;
  assign pend_o = pend_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed vector bench for intr_ctrl with N_SRC = 8.
module tb_intr_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] src_i, edge_mode_i, mask_i;
  logic       ack_i;
  logic       intr_o;
  logic [2:0] id_o;
  logic [7:0] pend_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  intr_ctrl #(.N_SRC(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .src_i       (src_i),
    .edge_mode_i (edge_mode_i),
    .mask_i      (mask_i),
    .intr_o      (intr_o),
    .id_o        (id_o),
    .ack_i       (ack_i),
    .pend_o      (pend_o)
  );

  // One record = inputs for one clock edge and the outputs required after it.
  typedef struct {
    string      name;
    logic [7:0] src;
    logic [7:0] edm;
    logic [7:0] msk;
    logic       ack;
    logic       x_intr;
    logic [2:0] x_id;
    logic [7:0] x_pend;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic [7:0] s, input logic [7:0] e,
                     input logic [7:0] m, input logic a, input logic xi,
                     input logic [2:0] xd, input logic [7:0] xp);
    vec_t v;
    v.name = nm; v.src = s; v.edm = e; v.msk = m; v.ack = a;
    v.x_intr = xi; v.x_id = xd; v.x_pend = xp;
    tbl.push_back(v);
  endtask

  // ID is only meaningful while intr_o is high, unless force_id is set.
  task automatic check(input string nm, input logic xi, input logic [2:0] xd,
                       input logic [7:0] xp, input logic force_id);
    n_vec++;
    if (intr_o !== xi || pend_o !== xp || ((xi || force_id) && id_o !== xd)) begin
      n_err++;
      $display("FAIL %s: got intr=%0b id=%0d pend=%02h, want intr=%0b id=%0d pend=%02h",
               nm, intr_o, id_o, pend_o, xi, xd, xp);
    end
  endtask

  task automatic step(input string nm, input logic [7:0] s, input logic [7:0] e,
                      input logic [7:0] m, input logic a, input logic xi,
                      input logic [2:0] xd, input logic [7:0] xp);
    @(negedge clk_i);
    src_i = s; edge_mode_i = e; mask_i = m; ack_i = a;
    @(posedge clk_i);
    #1;
    check(nm, xi, xd, xp, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0; src_i = '0; edge_mode_i = 8'hFF; mask_i = 8'hFF; ack_i = 1'b0;
    #12;
    check("reset_state", 1'b0, 3'd0, 8'h00, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // single edge on source 5
    add("se_pulse",   8'h20, 8'hFF, 8'hFF, 0, 0, 0, 8'h20);
    add("se_req",     8'h00, 8'hFF, 8'hFF, 0, 1, 5, 8'h20);
    add("se_ack",     8'h00, 8'hFF, 8'hFF, 1, 0, 0, 8'h00);
    add("se_quiet0",  8'h00, 8'hFF, 8'hFF, 0, 0, 0, 8'h00);
    add("se_quiet1",  8'h00, 8'hFF, 8'hFF, 0, 0, 0, 8'h00);
    // simultaneous 1,3,6 granted 6,3,1
    add("pr_pulse",   8'h4A, 8'hFF, 8'hFF, 0, 0, 0, 8'h4A);
    add("pr_req6",    8'h00, 8'hFF, 8'hFF, 0, 1, 6, 8'h4A);
    add("pr_hold6",   8'h00, 8'hFF, 8'hFF, 0, 1, 6, 8'h4A);
    add("pr_ack6",    8'h00, 8'hFF, 8'hFF, 1, 0, 0, 8'h0A);
    add("pr_req3",    8'h00, 8'hFF, 8'hFF, 0, 1, 3, 8'h0A);
    add("pr_ack3",    8'h00, 8'hFF, 8'hFF, 1, 0, 0, 8'h02);
    add("pr_req1",    8'h00, 8'hFF, 8'hFF, 0, 1, 1, 8'h02);
    add("pr_ack1",    8'h00, 8'hFF, 8'hFF, 1, 0, 0, 8'h00);
    add("pr_idle",    8'h00, 8'hFF, 8'hFF, 0, 0, 0, 8'h00);
    add("idle_ack",   8'h00, 8'hFF, 8'hFF, 1, 0, 0, 8'h00);
    // mask source 7, pulse 7 and 2
    add("mk_pulse",   8'h84, 8'hFF, 8'h7F, 0, 0, 0, 8'h84);
    add("mk_req2",    8'h00, 8'hFF, 8'h7F, 0, 1, 2, 8'h84);
    add("mk_ack2",    8'h00, 8'hFF, 8'h7F, 1, 0, 0, 8'h80);
    add("mk_held7",   8'h00, 8'hFF, 8'h7F, 0, 0, 0, 8'h80);
    add("mk_req7",    8'h00, 8'hFF, 8'hFF, 0, 1, 7, 8'h80);
    add("mk_ack7",    8'h00, 8'hFF, 8'hFF, 1, 0, 0, 8'h00);
    // source 4 level mode (mode switched while masked)
    add("lv_mode",    8'h00, 8'hEF, 8'hEF, 0, 0, 0, 8'h00);
    add("lv_high",    8'h10, 8'hEF, 8'hFF, 0, 0, 0, 8'h10);
    add("lv_req",     8'h10, 8'hEF, 8'hFF, 0, 1, 4, 8'h10);
    add("lv_ack",     8'h10, 8'hEF, 8'hFF, 1, 0, 0, 8'h10);
    add("lv_regrant", 8'h10, 8'hEF, 8'hFF, 0, 1, 4, 8'h10);
    add("lv_drop",    8'h00, 8'hEF, 8'hFF, 0, 1, 4, 8'h00);
    add("lv_maskreq", 8'h00, 8'hEF, 8'hEF, 0, 1, 4, 8'h00);
    add("lv_ack2",    8'h00, 8'hEF, 8'hFF, 1, 0, 0, 8'h00);
    add("lv_quiet0",  8'h00, 8'hEF, 8'hFF, 0, 0, 0, 8'h00);
    add("lv_quiet1",  8'h00, 8'hEF, 8'hFF, 0, 0, 0, 8'h00);
    add("lv_restore", 8'h00, 8'hFF, 8'hEF, 0, 0, 0, 8'h00);
    add("lv_unmask",  8'h00, 8'hFF, 8'hFF, 0, 0, 0, 8'h00);

    foreach (tbl[k])
      step(tbl[k].name, tbl[k].src, tbl[k].edm, tbl[k].msk, tbl[k].ack,
           tbl[k].x_intr, tbl[k].x_id, tbl[k].x_pend);

    // new rise on source 0 in the ack cycle must survive the clear
    step("sc_pulse",  8'h01, 8'hFF, 8'hFF, 0, 0, 0, 8'h01);
    step("sc_req",    8'h00, 8'hFF, 8'hFF, 0, 1, 0, 8'h01);
    step("sc_ackset", 8'h01, 8'hFF, 8'hFF, 1, 0, 0, 8'h01);
    step("sc_req2",   8'h00, 8'hFF, 8'hFF, 0, 1, 0, 8'h01);
    step("sc_ack2",   8'h00, 8'hFF, 8'hFF, 1, 0, 0, 8'h00);
    step("sc_quiet",  8'h00, 8'hFF, 8'hFF, 0, 0, 0, 8'h00);

    // asynchronous reset while in REQ with 1 and 3 pending
    step("rs_pulse",  8'h0A, 8'hFF, 8'hFF, 0, 0, 0, 8'h0A);
    step("rs_req3",   8'h00, 8'hFF, 8'hFF, 0, 1, 3, 8'h0A);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("rs_async", 1'b0, 3'd0, 8'h00, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++)
      step("rs_quiet", 8'h00, 8'hFF, 8'hFF, 0, 0, 0, 8'h00);
    step("rs_newpls", 8'h04, 8'hFF, 8'hFF, 0, 0, 0, 8'h04);
    step("rs_req2",   8'h00, 8'hFF, 8'hFF, 0, 1, 2, 8'h04);
    step("rs_ack2",   8'h00, 8'hFF, 8'hFF, 1, 0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Parametrised interrupt controller that replaces the fixed four-input, unregistered-priority scheme with N sources. Each source has a per-source mask and a selectable edge or level trigger, plus pending latches. A request/acknowledge handshake towards the CPU-side consumer holds the winning source ID stable until it is serviced. It sits between peripheral event lines and the core's interrupt input.

## Interface
Parameters:
- N_SRC, default 8: number of interrupt sources, legal range 2..32.
- ID_W, default $clog2(N_SRC): width of the source ID. Derived; never overridden.

Ports:
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset, asynchronous, active-low.
- src_i, input, N_SRC: raw source lines, synchronous to clk_i.
- edge_mode_i, input, N_SRC: per-source trigger mode; 1 = rising edge, 0 = level.
- mask_i, input, N_SRC: per-source enable; 1 = source may raise a request.
- intr_o, output, 1: request to the consumer; registered.
- id_o, output, ID_W: ID of the granted source; valid while intr_o = 1.
- ack_i, input, 1: consumer acknowledge; 1-cycle pulse.
- pend_o, output, N_SRC: pending vector, for status readback.

## Operation
- src_q: a registered copy of src_i, used for edge detection. rise = src_i & ~src_q.
- Pending update, every cycle:
  - Edge source: pend[i] <= (pend[i] & ~clr[i]) | rise[i]. The set wins over a clear in the same cycle, so no event is lost.
  - Level source: pend[i] <= src_i[i]. The clear has no effect on level sources.
- clr[i] = 1 only on the cycle where ack is accepted and id_o == i.
- Eligible vector: elig = pend & mask_i. Priority is fixed: the highest index wins.
- State machine, states IDLE and REQ:
  - IDLE: if elig != 0, go to REQ. intr_o <= 1 and id_o <= the highest set index of elig, both latched.
  - REQ: intr_o and id_o are held constant. ack_i = 1 accepts the request: go to IDLE, intr_o <= 0, and clear the pending bit of id_o if that source is edge-mode.
  - REQ is never withdrawn. Masking or de-asserting the granted source while in REQ does not drop intr_o; the consumer always sees a completed handshake.
  - ack_i in IDLE is ignored.
- A higher-priority source arriving during REQ does not pre-empt. It is granted on the next IDLE→REQ transition.
- Changing edge_mode_i takes effect on the next pending update. The bench applies mode changes only while the source is masked.

## Timing
- Reset values: intr_o = 0, id_o = 0, pend_o = 0, src_q = 0, state = IDLE.
- Latency, IDLE case: src_i rises before edge t, so pend is set at edge t and intr_o = 1 with a valid id_o at edge t+1. That is 2 edges from the src_i change to the request.
- Ack: ack_i high at edge a drops intr_o at edge a. The earliest next request is at edge a+1, so IDLE lasts at least one cycle.
- A level source still high after its ack is re-granted at edge a+1.
- A simultaneous rise on several edge sources latches all of them. They are granted one per handshake in descending index order.
- pend_o is the registered pend vector, unmasked.
- Reset mid-operation, including in REQ: all state is cleared at once and pending events are discarded.

## Structure
- Package intr_pkg holds:
  - typedef enum logic {IDLE, REQ} intr_state_e
  - the N_SRC range limit constant MAX_SRC = 32
- Sub-module intr_prio_enc: combinational, parameter N_SRC. Inputs are the eligible vector. Outputs are any_o and idx_o[ID_W] (the highest set index).
- The top level holds the edge detect, the pending registers, the state machine and the output registers.

## Test plan
All scenarios use N_SRC = 8.
- Reset: assert rst_ni = 0 mid-REQ, with pending = 8'h0A. Required: intr_o = 0, id_o = 0, pend_o = 0 immediately. After release, no request until a new event arrives.
- Single edge: all sources edge-mode, mask = 8'hFF, 1-cycle pulse on src_i[5]. Required: intr_o = 1 and id_o = 5 two edges later. After ack: intr_o = 0, pend_o = 0, and no second request.
- Priority and queueing: simultaneous 1-cycle pulses on sources 1, 3 and 6. Required: grants in the order 6, 3, 1, one per ack, with pend_o going 8'h4A → 8'h0A → 8'h02 → 8'h00.
- Masking: source 7 masked, source 2 unmasked, both pulsed. Required: id_o = 2, and pend_o[7] stays 1. Unmasking source 7 later produces id_o = 7 without any new pulse.
- Level mode: source 4 level-mode and held high across an ack. Required: re-granted at edge a+1 with id_o = 4. Drop src_i[4] during REQ: intr_o stays 1 until ack, then there is no further request.
- Set-beats-clear: an edge source 0 is granted, and a new rise on src_i[0] arrives in the same cycle as ack_i. Required: pend_o[0] stays 1 and there is a second grant with id_o = 0.
